mem_port_arbiter: RTL and testbench

- Shares the single 64-bit memory port (read enable/address, write enable/address, write data, read data) between NUM_REQ requester datapaths.
- One transaction in flight at a time.
- Round-robin arbitration, registered grant, per-requester response/ack pulse.
- Sits between the compute FSMs and the memory model.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of the requester-side request/response
// signals and the shared memory port of mem_port_arbiter.
//
// Handshake: a requester raises i_req_valid[k] with i_req_we[k],
// its address and write data, and holds all of them stable until
// o_req_grant[k] pulses. After the grant it may drop valid or present
// its next request. o_rsp_valid[k] pulses once per transaction: on a
// read, o_rsp_data carries the data in that cycle; on a write it only
// marks completion.
interface mem_port_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64
);
    // requester side
    logic [NUM_REQ-1:0]        i_req_valid;
    logic [NUM_REQ-1:0]        i_req_we;
    logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
    logic [NUM_REQ*DATA_W-1:0] i_req_wdata;
    logic [NUM_REQ-1:0]        o_req_grant;
    logic [NUM_REQ-1:0]        o_rsp_valid;
    logic [DATA_W-1:0]         o_rsp_data;

    // memory side
    logic                      o_read_en;
    logic [ADDR_W-1:0]         o_read_addr;
    logic                      o_write_en;
    logic [ADDR_W-1:0]         o_write_addr;
    logic [DATA_W-1:0]         o_data;
    logic [DATA_W-1:0]         i_data;

    // arbiter view
    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_data,
        output o_req_grant, o_rsp_valid, o_rsp_data,
        output o_read_en, o_read_addr, o_write_en, o_write_addr, o_data
    );

    // requesters + memory view
    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_data,
        input  o_req_grant, o_rsp_valid, o_rsp_data,
        input  o_read_en, o_read_addr, o_write_en, o_write_addr, o_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between NUM_REQ requesters.
// One transaction in flight at a time, registered one-hot grant and
// response pulses, all outputs registered.
//
// Build option: define MEM_PORT_ARBITER_FIXED_PRIO_EN to replace the
// round-robin choice with fixed priority (lowest requester index wins).
//
// Transaction timeline (cycle 0 = IDLE cycle in which the request is seen):
//   read : ISSUE in cycle 1, WAIT for RD_LAT cycles, i_data captured at the
//          end of cycle 1+RD_LAT, DONE (rsp_valid) in cycle RD_LAT+2.
//   write: ISSUE in cycle 1, DONE in cycle 2.
module mem_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int RD_LAT  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mem_port_arbiter_if.slave     io_bus,
    output logic [1:0]            o_dbg_state
);

    localparam int         IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] LAT_LAST = 4'(RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    // context of the transaction in flight
    logic [IDX_W-1:0]   r_win;
    logic               r_we;
    logic [3:0]         r_cnt;
`ifndef MEM_PORT_ARBITER_FIXED_PRIO_EN
    logic [IDX_W-1:0]   r_last;
`endif

    // registered outputs
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_read_en;
    logic [ADDR_W-1:0]  r_read_addr;
    logic               r_write_en;
    logic [ADDR_W-1:0]  r_write_addr;
    logic [DATA_W-1:0]  r_data;

    // arbitration result for the current IDLE cycle
    logic               w_any;
    logic [IDX_W-1:0]   w_win;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [NUM_REQ-1:0] w_sel_onehot;
    logic [NUM_REQ-1:0] w_win_onehot;

    // read data is taken in the RD_LAT-th WAIT cycle
    logic               w_capture;

    // next values of the registered outputs
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [NUM_REQ-1:0] w_rsp_valid_nxt;
    logic [DATA_W-1:0]  w_rsp_data_nxt;
    logic               w_read_en_nxt;
    logic [ADDR_W-1:0]  w_read_addr_nxt;
    logic               w_write_en_nxt;
    logic [ADDR_W-1:0]  w_write_addr_nxt;
    logic [DATA_W-1:0]  w_data_nxt;

    assign w_capture = (r_state == S_WAIT) && (r_cnt == LAT_LAST);

    // Winner selection: each requester gets a priority rank (0 = best);
    // the valid requester with the smallest rank wins. Round robin ranks
    // requester last+1 as 0, last+2 as 1, and so on modulo NUM_REQ.
    always_comb begin
        int best;
        int pri;
        w_any       = 1'b0;
        w_win       = '0;
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        best        = NUM_REQ;
        pri         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
            pri = k;
`else
            if (k > int'(r_last)) begin
                pri = k - int'(r_last) - 1;
            end else begin
                pri = k + NUM_REQ - int'(r_last) - 1;
            end
`endif
            if (io_bus.i_req_valid[k] && (pri < best)) begin
                best        = pri;
                w_any       = 1'b1;
                w_win       = IDX_W'(k);
                w_sel_we    = io_bus.i_req_we[k];
                w_sel_addr  = io_bus.i_req_addr[k*ADDR_W +: ADDR_W];
                w_sel_wdata = io_bus.i_req_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // One-hot forms of the fresh winner and of the latched winner.
    always_comb begin
        w_sel_onehot = '0;
        w_win_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sel_onehot[k] = (w_win == IDX_W'(k));
            w_win_onehot[k] = (r_win == IDX_W'(k));
        end
    end

    // State register plus the latched transaction context and wait counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_win   <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
`ifndef MEM_PORT_ARBITER_FIXED_PRIO_EN
            r_last  <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && w_any) begin
                r_win  <= w_win;
                r_we   <= w_sel_we;
`ifndef MEM_PORT_ARBITER_FIXED_PRIO_EN
                r_last <= w_win;
`endif
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= 4'd1;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = r_we ? S_DONE : S_WAIT;
            S_WAIT:  if (w_capture) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic: next values of the output registers, so that the
    // strobes/grant are visible during ISSUE and rsp_valid during DONE.
    // Addresses, write data and response data hold unless reloaded.
    always_comb begin
        w_grant_nxt      = '0;
        w_rsp_valid_nxt  = '0;
        w_rsp_data_nxt   = r_rsp_data;
        w_read_en_nxt    = 1'b0;
        w_read_addr_nxt  = r_read_addr;
        w_write_en_nxt   = 1'b0;
        w_write_addr_nxt = r_write_addr;
        w_data_nxt       = r_data;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_sel_onehot;
                    if (w_sel_we) begin
                        w_write_en_nxt   = 1'b1;
                        w_write_addr_nxt = w_sel_addr;
                        w_data_nxt       = w_sel_wdata;
                    end else begin
                        w_read_en_nxt   = 1'b1;
                        w_read_addr_nxt = w_sel_addr;
                    end
                end
            end
            S_ISSUE: begin
                if (r_we) w_rsp_valid_nxt = w_win_onehot;
            end
            S_WAIT: begin
                if (w_capture) begin
                    w_rsp_valid_nxt = w_win_onehot;
                    w_rsp_data_nxt  = io_bus.i_data;
                end
            end
            default: begin
            end
        endcase
    end

    // Output registers; reset clears every output, aborting any transaction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_read_en    <= 1'b0;
            r_read_addr  <= '0;
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_data       <= '0;
        end else begin
            r_grant      <= w_grant_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_data   <= w_rsp_data_nxt;
            r_read_en    <= w_read_en_nxt;
            r_read_addr  <= w_read_addr_nxt;
            r_write_en   <= w_write_en_nxt;
            r_write_addr <= w_write_addr_nxt;
            r_data       <= w_data_nxt;
        end
    end

    assign io_bus.o_req_grant  = r_grant;
    assign io_bus.o_rsp_valid  = r_rsp_valid;
    assign io_bus.o_rsp_data   = r_rsp_data;
    assign io_bus.o_read_en    = r_read_en;
    assign io_bus.o_read_addr  = r_read_addr;
    assign io_bus.o_write_en   = r_write_en;
    assign io_bus.o_write_addr = r_write_addr;
    assign io_bus.o_data       = r_data;
    assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter.
// Instance a (RD_LAT=1) is checked every cycle against a transaction-level
// reference model; instance b (RD_LAT=4) runs the read latency sweep.
module tb_mem_port_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;
    localparam int RD_LAT   = 1;
    localparam int RD_LAT_B = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
    mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();
    logic [1:0] dbg_a;
    logic [1:0] dbg_b;

    mem_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .io_bus      (bus_a),
        .o_dbg_state (dbg_a)
    );

    mem_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT_B)) u_dut_lat4 (
        .i_clk       (clk),
        .i_rst       (rst),
        .io_bus      (bus_b),
        .o_dbg_state (dbg_b)
    );

    // ---------------- bookkeeping ----------------
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // ---------------- reference model ----------------
    // One transaction record: who, what, and the cycles of grant and response.
    bit          m_active = 1'b0;
    int          m_who;
    bit          m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;
    int          m_grant_cyc;
    int          m_done_cyc;
    int          m_last = NUM_REQ - 1;
    logic [63:0] exp_read_addr  = '0;
    logic [63:0] exp_write_addr = '0;
    logic [63:0] exp_data       = '0;
    logic [63:0] exp_rsp_data   = '0;
    logic [63:0] mem_img [logic [63:0]];
    bit [NUM_REQ-1:0] hold_req = '0;
    logic [63:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] junk();
        return {$urandom, $urandom} | 64'h8000_0000_0000_0000;
    endfunction

    task automatic mem_read(input logic [63:0] a, output logic [63:0] d);
        if (!mem_img.exists(a)) mem_img[a] = {$urandom, $urandom} & 64'h7FFF_FFFF_FFFF_FFFF;
        d = mem_img[a];
    endtask

    // first set requester searching last+1, last+2, ... (or lowest index)
    function automatic int pick_winner(input logic [NUM_REQ-1:0] v, input int last);
`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
`else
        for (int s = 1; s <= NUM_REQ; s++) begin
            int idx;
            idx = (last + s) % NUM_REQ;
            if (v[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    // Called while inputs for cycle cyc are stable, before the sampling edge.
    task automatic model_sample();
        int w;
        if (rst) begin
            m_active       = 1'b0;
            m_last         = NUM_REQ - 1;
            exp_read_addr  = '0;
            exp_write_addr = '0;
            exp_data       = '0;
            exp_rsp_data   = '0;
            chk_en         = 1'b1;
            bus_a.i_data   = junk();
            return;
        end
        if (m_active && !m_we && (cyc == m_grant_cyc + RD_LAT)) bus_a.i_data = m_rdata;
        else bus_a.i_data = junk();
        if (!m_active || (cyc > m_done_cyc)) begin
            w = pick_winner(bus_a.i_req_valid, m_last);
            if (w >= 0) begin
                m_active    = 1'b1;
                m_who       = w;
                m_we        = bus_a.i_req_we[w];
                m_addr      = bus_a.i_req_addr[w*ADDR_W +: ADDR_W];
                m_wdata     = bus_a.i_req_wdata[w*DATA_W +: DATA_W];
                m_grant_cyc = cyc + 1;
                m_done_cyc  = m_we ? cyc + 2 : cyc + 2 + RD_LAT;
                if (m_we) mem_img[m_addr] = m_wdata;
                else mem_read(m_addr, m_rdata);
                m_last = w;
            end
        end
    endtask

    // Compare every output of instance a against the model for cycle cyc.
    task automatic check_outputs();
        logic [63:0] eg;
        logic [63:0] ev;
        logic [63:0] erd;
        logic [63:0] ewr;
        eg = '0; ev = '0; erd = '0; ewr = '0;
        if (m_active && (cyc == m_grant_cyc)) begin
            eg = 64'(1) << m_who;
            if (m_we) begin
                ewr            = 64'd1;
                exp_write_addr = m_addr;
                exp_data       = m_wdata;
            end else begin
                erd           = 64'd1;
                exp_read_addr = m_addr;
            end
        end
        if (m_active && (cyc == m_done_cyc)) begin
            ev = 64'(1) << m_who;
            if (!m_we) exp_rsp_data = m_rdata;
        end
        if (chk_en) begin
            check("grant",      64'(bus_a.o_req_grant),  eg);
            check("rsp_valid",  64'(bus_a.o_rsp_valid),  ev);
            check("rsp_data",   bus_a.o_rsp_data,        exp_rsp_data);
            check("read_en",    64'(bus_a.o_read_en),    erd);
            check("read_addr",  bus_a.o_read_addr,       exp_read_addr);
            check("write_en",   64'(bus_a.o_write_en),   ewr);
            check("write_addr", bus_a.o_write_addr,      exp_write_addr);
            check("wdata",      bus_a.o_data,            exp_data);
        end
        // requester side: release the request once granted unless told to hold
        if (m_active && (cyc == m_grant_cyc) && !hold_req[m_who]) bus_a.i_req_valid[m_who] = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_sample();
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic set_req(input int k, input bit we, input logic [63:0] addr, input logic [63:0] wdata);
        bus_a.i_req_valid[k] = 1'b1;
        bus_a.i_req_we[k]    = we;
        bus_a.i_req_addr[k*ADDR_W +: ADDR_W]  = addr;
        bus_a.i_req_wdata[k*DATA_W +: DATA_W] = wdata;
    endtask

    task automatic wait_rsp(input int k, input int exp_lat, input logic [63:0] exp_d,
                            input bit is_read, input string tag);
        int  t0;
        bit  found;
        t0    = cyc;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus_a.o_rsp_valid[k]) found = 1'b1;
        end
        check({tag, "_latency"}, found ? 64'(cyc - t0) : 64'hFFFF, 64'(exp_lat));
        if (is_read) check({tag, "_data"}, bus_a.o_rsp_data, exp_d);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g0;
        int g1;
        int ng;
        logic [63:0] e;

        bus_a.i_req_valid = '0; bus_a.i_req_we = '0; bus_a.i_req_addr = '0;
        bus_a.i_req_wdata = '0; bus_a.i_data = '0;
        bus_b.i_req_valid = '0; bus_b.i_req_we = '0; bus_b.i_req_addr = '0;
        bus_b.i_req_wdata = '0; bus_b.i_data = '0;

        // reset
        rst = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check("reset_dbg_b_rsp", 64'(bus_b.o_rsp_valid), 64'd0);

        // single read: req0, addr 0x10, memory returns 0x5
        mem_img[64'h10] = 64'h5;
        set_req(0, 1'b0, 64'h10, 64'h0);
        wait_rsp(0, 3, 64'h5, 1'b1, "single_read");
        tick();

        // single write: req1, addr 0x20, data 0xABCD; rsp_data keeps 0x5
        set_req(1, 1'b1, 64'h20, 64'hABCD);
        wait_rsp(1, 2, 64'h0, 1'b0, "single_write");
        check("single_write_rsp_data_kept", bus_a.o_rsp_data, 64'h5);
        tick();

        // contention: both requesters hold valid for 6 transactions
        hold_req = '1;
        set_req(0, 1'b0, 64'h30, 64'h0);
        set_req(1, 1'b1, 64'h38, 64'h77);
`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < 6; i++) exp_q.push_back(64'd0);
`else
        for (int i = 0; i < 6; i++) exp_q.push_back(64'(i % 2));
`endif
        for (int i = 0; i < 80 && exp_q.size() > 0; i++) begin
            tick();
            if (bus_a.o_req_grant != '0) begin
                e = exp_q.pop_front();
                check("contention_order", 64'(bus_a.o_req_grant), 64'(1) << e);
            end
        end
        check("contention_grants_left", 64'(exp_q.size()), 64'd0);
        hold_req = '0;
        bus_a.i_req_valid = '0;
        drain(8);

        // valid held through DONE: second grant only after the first finishes
        hold_req[0] = 1'b1;
        set_req(0, 1'b0, 64'h48, 64'h0);
        g0 = -1; g1 = -1; ng = 0;
        for (int i = 0; i < 30 && ng < 2; i++) begin
            tick();
            if (bus_a.o_req_grant[0]) begin
                if (ng == 0) g0 = cyc; else g1 = cyc;
                ng++;
            end
        end
        check("held_valid_gap", 64'(g1 - g0), 64'(RD_LAT + 3));
        hold_req = '0;
        bus_a.i_req_valid = '0;
        drain(6);

        // reset in the WAIT cycle of a read by requester 0
        set_req(0, 1'b0, 64'h50, 64'h0);
        tick();  // ISSUE
        tick();  // WAIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_rsp_valid", 64'(bus_a.o_rsp_valid), 64'd0);
        check("rst_mid_read_addr", bus_a.o_read_addr, 64'd0);
        check("rst_mid_rsp_data", bus_a.o_rsp_data, 64'd0);
        set_req(0, 1'b0, 64'h58, 64'h0);
        set_req(1, 1'b0, 64'h60, 64'h0);
        ng = 0;
        for (int i = 0; i < 10 && ng == 0; i++) begin
            tick();
            if (bus_a.o_req_grant != '0) begin
                check("rst_first_grant", 64'(bus_a.o_req_grant), 64'd1);
                ng = 1;
            end
        end
        check("rst_grant_seen", 64'(ng), 64'd1);
        drain(12);

        // randomized traffic
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!bus_a.i_req_valid[k]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(k, 1'($urandom_range(0, 1)), 64'($urandom_range(0, 15)) << 3,
                                {$urandom, $urandom});
                end else if ($urandom_range(0, 39) == 0) begin
                    bus_a.i_req_valid[k] = 1'b0;
                end
            end
            tick();
        end
        bus_a.i_req_valid = '0;
        drain(12);

        // read latency sweep on the RD_LAT=4 instance
        bus_b.i_req_valid[0] = 1'b1;
        bus_b.i_req_we[0]    = 1'b0;
        bus_b.i_req_addr[ADDR_W-1:0] = 64'h40;
        bus_b.i_data = junk();
        @(negedge clk);  // ISSUE
        check("lat4_grant", 64'(bus_b.o_req_grant), 64'd1);
        check("lat4_read_en", 64'(bus_b.o_read_en), 64'd1);
        check("lat4_read_addr", bus_b.o_read_addr, 64'h40);
        bus_b.i_req_valid[0] = 1'b0;
        for (int c = 1; c <= RD_LAT_B + 1; c++) begin
            check("lat4_wait_rsp_valid", 64'(bus_b.o_rsp_valid), 64'd0);
            check("lat4_wait_rsp_data", bus_b.o_rsp_data, 64'd0);
            bus_b.i_data = (c == 1 + RD_LAT_B) ? 64'h1234 : junk();
            @(negedge clk);
        end
        check("lat4_rsp_valid", 64'(bus_b.o_rsp_valid), 64'd1);
        check("lat4_rsp_data", bus_b.o_rsp_data, 64'h1234);
        bus_b.i_data = junk();
        @(negedge clk);
        check("lat4_rsp_valid_end", 64'(bus_b.o_rsp_valid), 64'd0);
        check("lat4_rsp_data_hold", bus_b.o_rsp_data, 64'h1234);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
